pipo_reg: RTL and testbench

Parameterised parallel-in/parallel-out register for the sequential-circuit library.
- Captures a full input word on a clock edge when load is asserted, and holds it otherwise.
- Adds a synchronous clear, per-lane load mask, valid flag and change-detect pulse, so it can be used as a pipeline or holding register between blocks.
- All outputs are registered; single clock domain.

---
 rtl/pipo_reg.sv | 81 ++++++++
 tb/tb_pipo_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipo_reg.sv
// Parallel-in/parallel-out register with synchronous clear, per-lane load mask,
// valid flag and change-detect pulse. Define PIPO_PARITY_EN to add a registered parity output.
module pipo_reg #(
    parameter int unsigned           WIDTH   = 4,
    parameter int unsigned           LANE_W  = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       clr,
    input  logic [WIDTH/LANE_W-1:0]    lane_en,
    input  logic [WIDTH-1:0]           pin,
    output logic [WIDTH-1:0]           pout,
    output logic                       valid,
    output logic                       changed
`ifdef PIPO_PARITY_EN
    ,
    output logic                       parity
`endif
);

    localparam int unsigned NUM_LANES = WIDTH / LANE_W;

    logic [WIDTH-1:0] pout_q, pout_d;
    logic [WIDTH-1:0] load_word;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;

    // Masked lanes keep their current value so an all-zero mask is a no-op load.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign load_word[i*LANE_W +: LANE_W] = lane_en[i] ? pin[i*LANE_W +: LANE_W]
                                                          : pout_q[i*LANE_W +: LANE_W];
    end

    always_comb begin
        pout_d    = pout_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (clr) begin
            pout_d  = RST_VAL;
            valid_d = 1'b0;
        end else if (load) begin
            pout_d    = load_word;
            valid_d   = 1'b1;
            changed_d = (load_word != pout_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pout_q    <= RST_VAL;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign pout    = pout_q;
    assign valid   = valid_q;
    assign changed = changed_q;

`ifdef PIPO_PARITY_EN
    logic parity_q;

    // Tracks pout_d so parity lands on the same edge as the data it covers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_q <= ^RST_VAL;
        end else begin
            parity_q <= ^pout_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_pipo_reg.sv
// Bench for pipo_reg: directed scenarios then random traffic, checked against a
// bit-level behavioural model of the register.
module tb_pipo_reg;

    localparam int WIDTH  = 4;
    localparam int LANE_W = 1;
    localparam int NL     = WIDTH / LANE_W;

    logic             clk = 1'b0;
    logic             rst, load, clr;
    logic [NL-1:0]    lane_en;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             valid, changed;
`ifdef PIPO_PARITY_EN
    logic             parity;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_pout;
    logic             m_valid, m_changed;

    pipo_reg #(.WIDTH(WIDTH), .LANE_W(LANE_W), .RST_VAL('0)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .clr     (clr),
        .lane_en (lane_en),
        .pin     (pin),
        .pout    (pout),
        .valid   (valid),
        .changed (changed)
`ifdef PIPO_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model update for one edge, from the rules: priority rst > clr > load > hold.
    task automatic model_edge();
        logic [WIDTH-1:0] nxt;
        int ones;
        if (!rst || clr) begin
            m_pout    = '0;
            m_valid   = 1'b0;
            m_changed = 1'b0;
        end else if (load) begin
            nxt = m_pout;
            for (int b = 0; b < WIDTH; b++)
                if (lane_en[b / LANE_W]) nxt[b] = pin[b];
            ones = 0;
            for (int b = 0; b < WIDTH; b++)
                if (nxt[b] != m_pout[b]) ones++;
            m_changed = (ones != 0);
            m_pout    = nxt;
            m_valid   = 1'b1;
        end else begin
            m_changed = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pout"},    32'(pout),    32'(m_pout));
        chk({tag, ".valid"},   32'(valid),   32'(m_valid));
        chk({tag, ".changed"}, 32'(changed), 32'(m_changed));
`ifdef PIPO_PARITY_EN
        begin
            int cnt = 0;
            for (int b = 0; b < WIDTH; b++) cnt += int'(m_pout[b]);
            chk({tag, ".parity"}, 32'(parity), 32'(cnt % 2));
        end
`endif
    endtask

    task automatic step(input logic r, input logic c, input logic l,
                        input logic [NL-1:0] en, input logic [WIDTH-1:0] d,
                        input string tag);
        rst = r; clr = c; load = l; lane_en = en; pin = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; load = 1'b0; lane_en = '0; pin = '0;
        m_pout = '0; m_valid = 1'b0; m_changed = 1'b0;
        @(negedge clk);

        // Reset ignores a simultaneous load
        step(1'b0, 1'b0, 1'b1, 4'b1111, 4'b1101, "reset");
        chk("reset.literal", 32'(pout), 32'h0);

        // Basic load then hold
        step(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1101, "load");
        chk("load.literal", 32'(pout), 32'hD);
        chk("load.chg", 32'(changed), 32'h1);
        step(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, "hold1");
        step(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, "hold2");
        chk("hold.chg", 32'(changed), 32'h0);

        // Masked load, repeated
        step(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0010, "mask1");
        chk("mask1.literal", 32'(pout), 32'hE);
        step(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0010, "mask2");
        chk("mask2.chg", 32'(changed), 32'h0);
        chk("mask2.valid", 32'(valid), 32'h1);

        // Empty mask still sets valid
        step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0101, "nomask");

        // Clear beats load
        step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, "clr");
        chk("clr.literal", 32'(pout), 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, "clr.hold");

        // Empty-mask load after clear: valid rises with no change
        step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, "nomask2");
        chk("nomask2.valid", 32'(valid), 32'h1);

        // Reset mid-operation across two edges
        step(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1101, "pre_rst");
        step(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0110, "midrst1");
        step(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0110, "midrst2");
        step(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0110, "post_rst");
        chk("post_rst.literal", 32'(pout), 32'h6);

        // Parity-relevant patterns
        step(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1101, "par1");
        step(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1001, "par0");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(15) != 0), ($urandom_range(7) == 0),
                 ($urandom_range(1) == 1), NL'($urandom), WIDTH'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
